data_memory: RTL

- Byte-addressable data memory for the single-cycle RISC-V datapath, directly downstream of the ALU.
- The ALU result is the effective address; rs2 data is the store data.
- Handles RV32I load/store widths:
  - stores: SB/SH/SW, written on the rising clock edge;
  - loads: LB/LH/LW/LBU/LHU, combinational read so a load completes in the same cycle.
- Little-endian. Word array is internal state, cleared by reset.

---
 rtl/data_memory_pkg.sv | 17 +
 rtl/dmem_load_align.sv | 34 +++
 rtl/data_memory.sv | 105 ++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// Shared encodings for the data memory: funct3 access sizes and byte-enable masks.
package data_memory_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned NUM_LANES = 4;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B    = 4'b0001;
    localparam logic [3:0] BE_H    = 4'b0011;
    localparam logic [3:0] BE_W    = 4'b1111;

endpackage

// File: rtl/dmem_load_align.sv
// Load path: selects the addressed byte/half of a word and sign- or zero-extends it.
module dmem_load_align
    import data_memory_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] word,
    input  logic [1:0]       lane,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] rd
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane extraction and extension by access type
    always_comb begin
        byte_s = word[{lane, 3'b000} +: 8];
        if (lane[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (funct3)
            F3_B:    rd = {{(WIDTH-8){byte_s[7]}}, byte_s};
            F3_BU:   rd = {{(WIDTH-8){1'b0}}, byte_s};
            F3_H:    rd = {{(WIDTH-16){half_s[15]}}, half_s};
            F3_HU:   rd = {{(WIDTH-16){1'b0}}, half_s};
            F3_W:    rd = word;
            default: rd = '0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable RV32I data memory: clocked SB/SH/SW, combinational loads.
// Optional macro DMEM_MISALIGN_TRAP_EN adds the MISALIGNED flag and suppresses misaligned accesses.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             WE,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] ADDR,
    input  logic [WIDTH-1:0] WD,
`ifdef DMEM_MISALIGN_TRAP_EN
    output logic             MISALIGNED,
`endif
    output logic [WIDTH-1:0] RD
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0]      mem_r [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] idx_s;
    logic [1:0]            lane_s;
    logic [3:0]            be_s;
    logic [3:0]            be_eff_s;
    logic [WIDTH-1:0]      wdata_s;
    logic [WIDTH-1:0]      align_rd_s;
    logic                  unused_addr_s;

    // High address bits fall away so accesses wrap modulo depth
    assign idx_s         = ADDR[ADDR_WIDTH+1:2];
    assign lane_s        = ADDR[1:0];
    assign unused_addr_s = ^ADDR[WIDTH-1:ADDR_WIDTH+2];

    // Byte-enable and lane-replicated store data per access size
    always_comb begin
        case (funct3)
            F3_B: begin
                be_s    = BE_B << lane_s;
                wdata_s = {4{WD[7:0]}};
            end
            F3_H: begin
                be_s    = BE_H << {lane_s[1], 1'b0};
                wdata_s = {2{WD[15:0]}};
            end
            F3_W: begin
                be_s    = BE_W;
                wdata_s = WD;
            end
            default: begin
                be_s    = BE_NONE;
                wdata_s = '0;
            end
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned_s;

    // Halfword needs ADDR[0]=0, word needs ADDR[1:0]=0
    always_comb begin
        if (funct3[1:0] == 2'b01) begin
            misaligned_s = ADDR[0];
        end else if (funct3[1:0] == 2'b10) begin
            misaligned_s = (ADDR[1:0] != 2'b00);
        end else begin
            misaligned_s = 1'b0;
        end
    end

    assign MISALIGNED = misaligned_s;
    assign be_eff_s   = misaligned_s ? BE_NONE : be_s;
    assign RD         = misaligned_s ? '0 : align_rd_s;
`else
    assign be_eff_s   = be_s;
    assign RD         = align_rd_s;
`endif

    // Word array: reset clears every word and outranks a same-edge store
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (WE) begin
            for (int b = 0; b < NUM_LANES; b++) begin
                if (be_eff_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
        end
    end

    dmem_load_align #(
        .WIDTH (WIDTH)
    ) u_load_align (
        .word   (mem_r[idx_s]),
        .lane   (lane_s),
        .funct3 (funct3),
        .rd     (align_rd_s)
    );

endmodule
